// File: rtl/urna_pkg.sv
// Shared types and helpers for the ballot-box vote sequencer.
// Optional null-vote counting is enabled by defining URNA_NULL_COUNT_EN.
package urna_pkg;

    localparam int URNA_DIGIT_MAX = 9;
    localparam int URNA_CODE_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENC1   = 3'd1,
        ST_DIG2   = 3'd2,
        ST_ENC2   = 3'd3,
        ST_REVIEW = 3'd4,
        ST_COMMIT = 3'd5,
        ST_LOCK   = 3'd6
    } urna_state_e;

    // Candidate number from two BCD digits; 99 is the largest result.
    function automatic logic [6:0] urna_cand(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

endpackage

// File: rtl/urna_tally_bank.sv
// Per-candidate saturating vote counters with a combinational read port.
// With URNA_NULL_COUNT_EN defined it also holds the saturating null-vote counter.
module urna_tally_bank
    import urna_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int TALLY_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_en,
    input  logic [6:0]         inc_idx,
`ifdef URNA_NULL_COUNT_EN
    input  logic               null_inc,
    output logic [TALLY_W-1:0] null_votes,
`endif
    input  logic [6:0]         rd_idx,
    output logic [TALLY_W-1:0] rd_tally
);

    logic [TALLY_W-1:0] tally_view [NUM_CAND];

    generate
        for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cnt
            logic [TALLY_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (inc_en && inc_idx == 7'(gi) && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + TALLY_W'(1);
                end
            end

            assign tally_view[gi] = cnt_reg;
        end
    endgenerate

    // Indices past the last candidate read back as zero.
    always_comb begin
        rd_tally = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (rd_idx == 7'(i)) begin
                rd_tally = tally_view[i];
            end
        end
    end

`ifdef URNA_NULL_COUNT_EN
    logic [TALLY_W-1:0] null_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            null_reg <= '0;
        end else if (null_inc && null_reg != '1) begin
            null_reg <= null_reg + TALLY_W'(1);
        end
    end

    assign null_votes = null_reg;
`endif

endmodule

// File: rtl/urna_vote_sequencer.sv
// Keypad-to-encoder vote sequencer: two-digit entry, review, commit and lockout.
// URNA_NULL_COUNT_EN turns out-of-range confirms into counted null votes.
module urna_vote_sequencer
    import urna_pkg::*;
#(
    parameter int NUM_CAND    = 4,
    parameter int TALLY_W     = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_digit,
    input  logic                     key_confirm,
    input  logic                     key_cancel,
    output logic [3:0]               enc_digit,
    output logic                     enc_strobe,
    input  logic [URNA_CODE_W-1:0]   enc_code,
    output logic [2*URNA_CODE_W-1:0] code_out,
    output logic                     busy,
    output logic                     key_err,
    output logic                     vote_done,
    input  logic [6:0]               rd_idx,
    output logic [TALLY_W-1:0]       rd_tally,
`ifdef URNA_NULL_COUNT_EN
    output logic [TALLY_W-1:0]       null_votes,
`endif
    output logic [15:0]              total_votes
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    urna_state_e              state_reg, state_next;
    logic [3:0]               tens_reg, tens_next;
    logic [3:0]               units_reg, units_next;
    logic [2*URNA_CODE_W-1:0] code_reg, code_next;
    logic [3:0]               enc_digit_reg, enc_digit_next;
    logic                     enc_strobe_reg, enc_strobe_next;
    logic                     key_err_reg, key_err_next;
    logic                     cap_tens_reg, cap_tens_next;
    logic                     cap_units_reg, cap_units_next;
    logic [LOCK_W-1:0]        lock_reg, lock_next;
    logic [15:0]              total_reg, total_next;
    logic [6:0]               cand;
    logic                     in_range;
    logic                     digit_ok;
    logic                     tally_inc;
`ifdef URNA_NULL_COUNT_EN
    logic                     null_inc;
`endif

    assign cand     = urna_cand(tens_reg, units_reg);
    assign in_range = cand < 7'(NUM_CAND);
    assign digit_ok = key_digit <= 4'(URNA_DIGIT_MAX);

    always_comb begin
        state_next      = state_reg;
        tens_next       = tens_reg;
        units_next      = units_reg;
        code_next       = code_reg;
        enc_digit_next  = enc_digit_reg;
        enc_strobe_next = 1'b0;
        key_err_next    = 1'b0;
        cap_tens_next   = 1'b0;
        cap_units_next  = 1'b0;
        lock_next       = lock_reg;
        total_next      = total_reg;
        tally_inc       = 1'b0;
`ifdef URNA_NULL_COUNT_EN
        null_inc        = 1'b0;
`endif
        // The encoder answers one cycle after it sees the strobe, so each capture
        // lands one cycle after leaving the ENC state; a cancel below overrides it.
        if (cap_tens_reg) code_next[2*URNA_CODE_W-1:URNA_CODE_W] = enc_code;
        if (cap_units_reg) code_next[URNA_CODE_W-1:0] = enc_code;

        case (state_reg)
            ST_IDLE: begin
                if (key_valid) begin
                    if (digit_ok) begin
                        tens_next       = key_digit;
                        enc_digit_next  = key_digit;
                        enc_strobe_next = 1'b1;
                        state_next      = ST_ENC1;
                    end else begin
                        key_err_next = 1'b1;
                    end
                end
            end
            ST_ENC1: begin
                cap_tens_next = 1'b1;
                state_next    = ST_DIG2;
            end
            ST_DIG2: begin
                if (key_cancel) begin
                    code_next  = '0;
                    state_next = ST_IDLE;
                end else if (key_valid) begin
                    if (digit_ok) begin
                        units_next      = key_digit;
                        enc_digit_next  = key_digit;
                        enc_strobe_next = 1'b1;
                        state_next      = ST_ENC2;
                    end else begin
                        key_err_next = 1'b1;
                    end
                end
            end
            ST_ENC2: begin
                cap_units_next = 1'b1;
                state_next     = ST_REVIEW;
            end
            ST_REVIEW: begin
                if (key_cancel) begin
                    code_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    if (key_valid) key_err_next = 1'b1;
                    if (key_confirm) begin
                        if (in_range) begin
                            state_next = ST_COMMIT;
                        end else begin
`ifdef URNA_NULL_COUNT_EN
                            state_next = ST_COMMIT;
`else
                            key_err_next = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_COMMIT: begin
                tally_inc  = in_range;
`ifdef URNA_NULL_COUNT_EN
                null_inc   = !in_range;
`endif
                total_next = total_reg + 16'd1;
                lock_next  = LOCK_W'(LOCK_CYCLES);
                state_next = ST_LOCK;
            end
            ST_LOCK: begin
                if (lock_reg == '0) begin
                    code_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    lock_next = lock_reg - LOCK_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            tens_reg       <= '0;
            units_reg      <= '0;
            code_reg       <= '0;
            enc_digit_reg  <= '0;
            enc_strobe_reg <= 1'b0;
            key_err_reg    <= 1'b0;
            cap_tens_reg   <= 1'b0;
            cap_units_reg  <= 1'b0;
            lock_reg       <= '0;
            total_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            tens_reg       <= tens_next;
            units_reg      <= units_next;
            code_reg       <= code_next;
            enc_digit_reg  <= enc_digit_next;
            enc_strobe_reg <= enc_strobe_next;
            key_err_reg    <= key_err_next;
            cap_tens_reg   <= cap_tens_next;
            cap_units_reg  <= cap_units_next;
            lock_reg       <= lock_next;
            total_reg      <= total_next;
        end
    end

    urna_tally_bank #(
        .NUM_CAND (NUM_CAND),
        .TALLY_W  (TALLY_W)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .inc_en     (tally_inc),
        .inc_idx    (cand),
`ifdef URNA_NULL_COUNT_EN
        .null_inc   (null_inc),
        .null_votes (null_votes),
`endif
        .rd_idx     (rd_idx),
        .rd_tally   (rd_tally)
    );

    assign enc_digit   = enc_digit_reg;
    assign enc_strobe  = enc_strobe_reg;
    assign code_out    = code_reg;
    assign busy        = state_reg != ST_IDLE;
    assign key_err     = key_err_reg;
    assign vote_done   = state_reg == ST_COMMIT;
    assign total_votes = total_reg;

endmodule

// File: tb/tb_urna_vote_sequencer.sv
// Self-checking bench for urna_vote_sequencer: a protocol-level timeline model
// schedules expected outputs per cycle; one compare process checks them every cycle.
module tb_urna_vote_sequencer;

    localparam int NC   = 4;
    localparam int TW   = 8;
    localparam int LC   = 16;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_valid = 1'b0;
    logic [3:0]    key_digit = '0;
    logic          key_confirm = 1'b0;
    logic          key_cancel = 1'b0;
    logic [3:0]    enc_digit;
    logic          enc_strobe;
    logic [4:0]    enc_code;
    logic [9:0]    code_out;
    logic          busy, key_err, vote_done;
    logic [6:0]    rd_idx = '0;
    logic [TW-1:0] rd_tally;
    logic [15:0]   total_votes;
`ifdef URNA_NULL_COUNT_EN
    logic [TW-1:0] null_votes;
`endif

    urna_vote_sequencer #(.NUM_CAND(NC), .TALLY_W(TW), .LOCK_CYCLES(LC)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .key_confirm (key_confirm),
        .key_cancel  (key_cancel),
        .enc_digit   (enc_digit),
        .enc_strobe  (enc_strobe),
        .enc_code    (enc_code),
        .code_out    (code_out),
        .busy        (busy),
        .key_err     (key_err),
        .vote_done   (vote_done),
        .rd_idx      (rd_idx),
        .rd_tally    (rd_tally),
`ifdef URNA_NULL_COUNT_EN
        .null_votes  (null_votes),
`endif
        .total_votes (total_votes)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] encf(input int d);
        return 5'(d * 3 + 1);
    endfunction

    // Encoder stand-in: result valid only in the cycle after the strobe, junk otherwise.
    always @(posedge clk) enc_code <= enc_strobe ? encf(int'(enc_digit)) : 5'($urandom_range(31));

    int nchk = 0, nbad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s slot=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Timeline of expected outputs, keyed by sample slot (cyc value at negedge).
    bit p_strobe [int];
    bit p_err    [int];
    bit p_done   [int];
    int ev_digit [int];
    int ev_code  [int];
    int ev_busy  [int];
    int ev_total [int];
    int ev_tally [int];
    int ev_null  [int];

    int x_code, x_digit, x_busy, x_total, x_null;
    int x_tally [NC];
    int n_strobe = 0, n_err = 0, n_done = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset !== 1'b0) begin
                x_code = 0; x_digit = 0; x_busy = 0; x_total = 0; x_null = 0;
                for (int i = 0; i < NC; i++) x_tally[i] = 0;
            end else begin
                int s;
                s = cyc;
                if (ev_code.exists(s))  x_code  = ev_code[s];
                if (ev_digit.exists(s)) x_digit = ev_digit[s];
                if (ev_busy.exists(s))  x_busy  = ev_busy[s];
                if (ev_total.exists(s)) x_total = ev_total[s];
                if (ev_null.exists(s))  x_null  = ev_null[s];
                if (ev_tally.exists(s)) x_tally[ev_tally[s] >> 16] = ev_tally[s] & 16'hffff;
                chk("enc_strobe", int'(enc_strobe), p_strobe.exists(s));
                chk("key_err", int'(key_err), p_err.exists(s));
                chk("vote_done", int'(vote_done), p_done.exists(s));
                chk("enc_digit", int'(enc_digit), x_digit);
                chk("code_out", int'(code_out), x_code);
                chk("busy", int'(busy), x_busy);
                chk("total_votes", int'(total_votes), x_total);
                chk("rd_tally", int'(rd_tally), (int'(rd_idx) < NC) ? x_tally[rd_idx] : 0);
`ifdef URNA_NULL_COUNT_EN
                chk("null_votes", int'(null_votes), x_null);
`endif
                if (enc_strobe === 1'b1) n_strobe++;
                if (key_err === 1'b1) n_err++;
                if (vote_done === 1'b1) n_done++;
            end
        end
    end

    // Protocol-level model of the voter session.
    int m_phase, m_ready, m_tens, m_units, m_total, m_null;
    int m_tally [NC];
    int rsel [6] = '{0, 1, 2, 3, 4, 99};

    task automatic commit_vote(input int e, input int cand, input bit is_null);
        p_done[e] = 1'b1;
        if (is_null) begin
            if (m_null < TMAX) m_null++;
            ev_null[e+1] = m_null;
        end else begin
            if (m_tally[cand] < TMAX) m_tally[cand]++;
            ev_tally[e+1] = (cand << 16) | m_tally[cand];
        end
        m_total = (m_total + 1) % 65536;
        ev_total[e+1]    = m_total;
        ev_busy[e+LC+2]  = 0;
        ev_code[e+LC+2]  = 0;
        m_phase = 0;
        m_ready = e + LC + 3;
    endtask

    task automatic model_key(input int e, input bit v, input int d, input bit c, input bit x);
        int cand;
        if (e < m_ready) return;
        case (m_phase)
            0: if (v) begin
                if (d <= 9) begin
                    m_tens = d; p_strobe[e] = 1'b1; ev_digit[e] = d; ev_busy[e] = 1;
                    ev_code[e+2] = int'(encf(d)) << 5;
                    m_phase = 1; m_ready = e + 2;
                end else p_err[e] = 1'b1;
            end
            1: if (x) begin
                ev_code[e] = 0; ev_busy[e] = 0; m_phase = 0;
            end else if (v) begin
                if (d <= 9) begin
                    m_units = d; p_strobe[e] = 1'b1; ev_digit[e] = d;
                    ev_code[e+2] = (int'(encf(m_tens)) << 5) | int'(encf(d));
                    m_phase = 2; m_ready = e + 2;
                end else p_err[e] = 1'b1;
            end
            default: if (x) begin
                ev_code[e] = 0; ev_busy[e] = 0; m_phase = 0;
            end else begin
                if (v) p_err[e] = 1'b1;
                if (c) begin
                    cand = m_tens * 10 + m_units;
                    if (cand < NC) commit_vote(e, cand, 1'b0);
                    else begin
`ifdef URNA_NULL_COUNT_EN
                        commit_vote(e, cand, 1'b1);
`else
                        p_err[e] = 1'b1;
`endif
                    end
                end
            end
        endcase
    endtask

    task automatic press(input bit v, input int d, input bit c, input bit x);
        @(negedge clk);
        key_valid = v; key_digit = 4'(d); key_confirm = c; key_cancel = x;
        rd_idx = 7'(rsel[cyc % 6]);
        model_key(cyc + 1, v, d, c, x);
    endtask

    task automatic idle(input int n);
        repeat (n) press(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (cyc + 2 < m_ready && g < 64) begin
            press(1'b0, 0, 1'b0, 1'b0);
            g++;
        end
    endtask

    task automatic vote(input int d1, input int d2);
        press(1'b1, d1, 1'b0, 1'b0); wait_ready();
        press(1'b1, d2, 1'b0, 1'b0); wait_ready();
        press(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic wait_idle(output int t);
        t = -1;
        for (int k = 0; k < 60; k++) begin
            press(1'b0, 0, 1'b0, 1'b0);
            if (busy === 1'b0) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic lit_tally(input int idx, input int val);
        press(1'b0, 0, 1'b0, 1'b0);
        rd_idx = 7'(idx);
        #2;
        chk($sformatf("lit_tally%0d", idx), int'(rd_tally), val);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        key_valid = 1'b0; key_confirm = 1'b0; key_cancel = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_code"}, int'(code_out), 0);
        chk({tag, "_strobe"}, int'(enc_strobe), 0);
        chk({tag, "_digit"}, int'(enc_digit), 0);
        chk({tag, "_err"}, int'(key_err), 0);
        chk({tag, "_done"}, int'(vote_done), 0);
        chk({tag, "_total"}, int'(total_votes), 0);
        p_strobe.delete(); p_err.delete(); p_done.delete();
        ev_digit.delete(); ev_code.delete(); ev_busy.delete();
        ev_total.delete(); ev_tally.delete(); ev_null.delete();
        m_phase = 0; m_ready = 0; m_total = 0; m_null = 0;
        for (int i = 0; i < NC; i++) m_tally[i] = 0;
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        int t, e_conf, s0, r0, d0;

        do_reset("rst0");

        // Vote 0,2 then confirm: two strobes, tally[2]=1, lockout length.
        s0 = n_strobe;
        vote(0, 2);
        e_conf = cyc + 1;
        wait_idle(t);
        chk("busy_fall_delay", t - e_conf, LC + 2);
        chk("t1_strobes", n_strobe - s0, 2);
        chk("t1_total", int'(total_votes), 1);
        lit_tally(2, 1);

        // Out-of-range digit in IDLE.
        s0 = n_strobe; r0 = n_err;
        press(1'b1, 12, 1'b0, 1'b0);
        idle(2);
        chk("bad_digit_err", n_err - r0, 1);
        chk("bad_digit_strobe", n_strobe - s0, 0);
        chk("bad_digit_busy", int'(busy), 0);

        // Cancel in REVIEW, then confirm+cancel together.
        press(1'b1, 0, 1'b0, 1'b0); wait_ready();
        press(1'b1, 1, 1'b0, 1'b0); wait_ready();
        press(1'b0, 0, 1'b0, 1'b1);
        idle(2);
        chk("cancel_code", int'(code_out), 0);
        chk("cancel_busy", int'(busy), 0);
        d0 = n_done;
        press(1'b1, 0, 1'b0, 1'b0); wait_ready();
        press(1'b1, 3, 1'b0, 1'b0); wait_ready();
        press(1'b0, 0, 1'b1, 1'b1);
        idle(2);
        chk("conf_cancel_busy", int'(busy), 0);
        chk("conf_cancel_done", n_done - d0, 0);
        chk("conf_cancel_total", int'(total_votes), 1);
        lit_tally(0, 0);
        lit_tally(1, 0);

        // Dropped key in ENC1, bad digit in DIG2, digit in REVIEW, digit+cancel.
        r0 = n_err;
        press(1'b1, 1, 1'b0, 1'b0);
        press(1'b1, 7, 1'b0, 1'b0);
        wait_ready();
        press(1'b1, 15, 1'b0, 1'b0);
        press(1'b1, 2, 1'b0, 1'b0);
        wait_ready();
        idle(3);
        chk("review_code", int'(code_out), 135);
        press(1'b1, 4, 1'b0, 1'b0);
        press(1'b1, 5, 1'b0, 1'b1);
        idle(2);
        chk("edge_keys_err", n_err - r0, 2);
        chk("digit_cancel_busy", int'(busy), 0);
        press(1'b1, 3, 1'b0, 1'b1);
        idle(1);
        chk("idle_digit_wins", int'(busy), 1);
        press(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // Out-of-range candidate 57.
        r0 = n_err;
        vote(5, 7);
`ifdef URNA_NULL_COUNT_EN
        wait_idle(t);
        chk("null_votes_lit", int'(null_votes), 1);
        chk("null_total", int'(total_votes), 2);
`else
        idle(3);
        chk("oor_err", n_err - r0, 1);
        chk("oor_hold_busy", int'(busy), 1);
        chk("oor_total", int'(total_votes), 1);
        press(1'b0, 0, 1'b0, 1'b1);
        idle(2);
`endif

        // Keys during lockout are ignored without error.
        r0 = n_err;
        vote(0, 1);
        idle(4);
        press(1'b1, 3, 1'b0, 1'b0);
        press(1'b1, 11, 1'b0, 1'b0);
        wait_ready();
        idle(2);
        chk("lock_ignore_err", n_err - r0, 0);

        // Reset while in ENC2, then a normal vote.
        press(1'b1, 1, 1'b0, 1'b0); wait_ready();
        press(1'b1, 2, 1'b0, 1'b0);
        do_reset("rst_enc2");
        vote(0, 1);
        wait_ready();
        idle(1);
        chk("post_reset_total", int'(total_votes), 1);
        lit_tally(1, 1);
        lit_tally(2, 0);

        // Saturation: 256 votes for candidate 3.
        do_reset("rst_sat");
        for (int i = 0; i < 256; i++) begin
            vote(0, 3);
            wait_ready();
        end
        idle(1);
        lit_tally(3, 255);
        chk("sat_total", int'(total_votes), 256);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/urna_vote_sequencer.md
# urna_vote_sequencer

Sequencer for the ballot-box datapath. It collects a two-digit candidate number from the keypad and drives the shared 5-bit digit encoder once per digit. It holds both encoded digits for voter review, and on confirm commits the vote to a per-candidate tally bank, then locks the keypad for a fixed interval. It sits between the keypad front end and the encoder/display path, and is the only agent that strobes the encoder.

## Interface
- `NUM_CAND`, default 4: number of valid candidates; candidate numbers 00..NUM_CAND-1 (max 99).
- `TALLY_W`, default 8: width of each tally counter.
- `LOCK_CYCLES`, default 16: keypad lockout length after a commit (≥1).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `key_valid` in 1: single-cycle keypad digit strobe.
- `key_digit` in 4: digit value, sampled when `key_valid` is high.
- `key_confirm` in 1: single-cycle confirm strobe.
- `key_cancel` in 1: single-cycle cancel strobe.
- `enc_digit` out 4: digit presented to the encoder.
- `enc_strobe` out 1: one-cycle encode request to the encoder.
- `enc_code` in 5: encoder result, valid the cycle after `enc_strobe`.
- `code_out` out 10: {tens code, units code} for display.
- `busy` out 1: high in every state except IDLE.
- `key_err` out 1: one-cycle pulse on a rejected key.
- `vote_done` out 1: one-cycle pulse when a vote is committed.
- `rd_idx` in 7: tally read index.
- `rd_tally` out TALLY_W: tally for `rd_idx`, combinational; 0 if `rd_idx` ≥ NUM_CAND.
- `total_votes` out 16: number of commits since reset.

## Operation
- States: IDLE, ENC1, DIG2, ENC2, REVIEW, COMMIT, LOCK.
- IDLE: `key_valid` with digit 0..9 latches `tens`, sets `enc_digit` = digit, pulses `enc_strobe`, and moves to ENC1. Digits 10..15 pulse `key_err` and the state does not change.
- ENC1: captures `enc_code` into `code_out[9:5]`, then moves to DIG2. The duration is exactly one cycle.
- DIG2: a valid digit latches `units`, strobes the encoder, and moves to ENC2. An invalid digit pulses `key_err`. `key_cancel` returns to IDLE and clears `code_out`.
- ENC2: captures `enc_code` into `code_out[4:0]`, then moves to REVIEW.
- REVIEW: `key_cancel` returns to IDLE and clears `code_out`. `key_confirm` moves to COMMIT when cand = tens*10+units < NUM_CAND; the out-of-range case is defined under Configuration. `key_valid` pulses `key_err`.
- COMMIT: a single cycle. Increments `tally[cand]` (saturating at all-ones) and `total_votes` (wrapping), pulses `vote_done`, loads the lock counter with LOCK_CYCLES, and moves to LOCK.
- LOCK: all keys are ignored without `key_err`. The counter decrements each cycle; at 0 the block clears `code_out` and moves to IDLE.
- Confirm and cancel in the same cycle: cancel wins. Digit and cancel in the same cycle: cancel wins in DIG2 and REVIEW; the digit wins in IDLE.
- Keys arriving in ENC1, ENC2 or COMMIT are dropped silently.

## Timing
- Reset values: state IDLE, all tallies 0, `total_votes` 0, `code_out` 0, `enc_digit` 0, all pulse outputs 0, `busy` 0.
- Reset mid-vote aborts the vote without committing it.
- The digit key is accepted at edge N, `enc_strobe` is high during cycle N+1, and `code_out` updates at edge N+2.
- Confirm is accepted at edge N, `vote_done` is high during cycle N+1, and the tally is visible on `rd_tally` from edge N+1.
- Confirm to IDLE takes LOCK_CYCLES+2 cycles.
- `enc_strobe` is never high on two consecutive cycles.

## Configuration
- `URNA_NULL_COUNT_EN` defined: an out-of-range confirm commits a null vote. It increments a `null_votes` counter (TALLY_W wide, saturating, exposed as an extra output) and `total_votes`, then follows the normal COMMIT/LOCK path.
- `URNA_NULL_COUNT_EN` undefined: an out-of-range confirm pulses `key_err` and the block stays in REVIEW. The `null_votes` port is absent.

## Structure
- Package `urna_pkg` holds:
  - the state enum;
  - `URNA_DIGIT_MAX` = 9;
  - `URNA_CODE_W` = 5;
  - the function computing cand from two BCD digits.
- Sub-module `urna_tally_bank` holds the NUM_CAND saturating counters, with an increment port and a combinational read port. The null counter is also placed there when `URNA_NULL_COUNT_EN` is defined.

## Test plan
- Keys 0, 2, confirm (NUM_CAND=4) → one `enc_strobe` per digit with `enc_digit` 0 then 2; `vote_done` pulse; `rd_tally[2]` = 1; `total_votes` = 1; `busy` falls LOCK_CYCLES+2 cycles after confirm.
- Key 12 in IDLE → `key_err` pulse, no `enc_strobe`, state stays IDLE.
- Keys 0, 1, cancel → `code_out` = 0, IDLE, all tallies unchanged; confirm and cancel asserted together in REVIEW → IDLE.
- Keys 5, 7, confirm → with the macro defined, `null_votes` = 1 and `total_votes` = 1; with it undefined, `key_err` pulses and REVIEW is held.
- 256 votes for candidate 3 with TALLY_W=8 → `rd_tally[3]` saturates at 255, `total_votes` = 256.
- Reset asserted while in ENC2 → all outputs at reset values immediately; the next vote proceeds normally.
